// File: rtl/vga_frame_buffer_writer.sv
// Avalon-ST sink to Avalon-MM write master: writes one frame per packet into the SDRAM frame buffer.
// Define VGA_FB_WRITER_CLIP_EN to discard overflow words; by default overflow wraps to the frame base.
module vga_frame_buffer_writer #(
    parameter int                       MM_ADDR_WIDTH    = 32,
    parameter int                       MM_DATA_WIDTH    = 32,
    parameter logic [MM_ADDR_WIDTH-1:0] MM_START_ADDRESS = '0,
    parameter int                       MM_FRAME_SIZE    = 640 * 480 * 16 / 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       address_wr,
    input  logic [MM_ADDR_WIDTH-1:0]   address,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [MM_DATA_WIDTH-1:0]   st_data,
    input  logic                       st_startofpacket,
    input  logic                       st_endofpacket,
    output logic                       mm_write,
    output logic [MM_ADDR_WIDTH-1:0]   mm_address,
    output logic [MM_DATA_WIDTH/8-1:0] mm_byteenable,
    output logic [MM_DATA_WIDTH-1:0]   mm_writedata,
    input  logic                       mm_waitrequest,
    output logic                       frame_done,
    output logic                       frame_error
);

    localparam int BPW = MM_DATA_WIDTH / 8;
    localparam logic [MM_ADDR_WIDTH-1:0] BPW_A   = MM_ADDR_WIDTH'(BPW);
    localparam logic [MM_ADDR_WIDTH-1:0] FRAME_A = MM_ADDR_WIDTH'(MM_FRAME_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITING,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

    state_t                     state_reg, state_next;
    logic [MM_ADDR_WIDTH-1:0]   base_reg;
    logic [MM_ADDR_WIDTH-1:0]   frame_base_reg, frame_base_next;
    logic [MM_ADDR_WIDTH-1:0]   end_reg, end_next;
    logic [MM_ADDR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
    logic                       err_reg, err_next;
    logic                       mm_write_reg, mm_write_next;
    logic [MM_ADDR_WIDTH-1:0]   mm_address_reg, mm_address_next;
    logic [MM_DATA_WIDTH-1:0]   mm_writedata_reg, mm_writedata_next;
    logic                       pulse_done_reg, pulse_done_next;
    logic                       pulse_err_reg, pulse_err_next;

    logic                       beat_acc;
    logic                       do_start;
    logic                       do_write;
    logic                       flush_done;
    logic [MM_ADDR_WIDTH-1:0]   write_addr;

    genvar gi;
    generate
        for (gi = 0; gi < BPW; gi++) begin : g_byteenable
            assign mm_byteenable[gi] = 1'b1;
        end
    endgenerate

    assign st_ready     = (state_reg != ST_FLUSH) && !(mm_write_reg && mm_waitrequest);
    assign beat_acc     = st_valid && st_ready;
    assign mm_write     = mm_write_reg;
    assign mm_address   = mm_address_reg;
    assign mm_writedata = mm_writedata_reg;
    // FLUSH completion is reported in the cycle the last write is seen taken (or the bus is already idle).
    assign frame_done   = pulse_done_reg || flush_done;
    assign frame_error  = pulse_err_reg || (flush_done && err_reg);

    always_comb begin
        state_next        = state_reg;
        frame_base_next   = frame_base_reg;
        end_next          = end_reg;
        wr_ptr_next       = wr_ptr_reg;
        err_next          = err_reg;
        mm_write_next     = mm_write_reg && mm_waitrequest;
        mm_address_next   = mm_address_reg;
        mm_writedata_next = mm_writedata_reg;
        pulse_done_next   = 1'b0;
        pulse_err_next    = 1'b0;
        do_start          = 1'b0;
        do_write          = 1'b0;
        flush_done        = 1'b0;
        write_addr        = wr_ptr_reg;

        case (state_reg)
            ST_IDLE: begin
                if (beat_acc && st_startofpacket) begin
                    if (st_endofpacket) begin
                        pulse_done_next = 1'b1;
                        pulse_err_next  = 1'b1;
                    end else begin
                        do_start = 1'b1;
                    end
                end
            end
            ST_WRITING: begin
                if (beat_acc) begin
                    if (st_endofpacket) begin
                        state_next = ST_FLUSH;
                        if (wr_ptr_reg != end_reg) begin
                            err_next = 1'b1;
                        end
                    end else if (st_startofpacket) begin
                        do_start       = 1'b1;
                        pulse_err_next = 1'b1;
                    end else if (wr_ptr_reg == end_reg) begin
                        err_next = 1'b1;
`ifdef VGA_FB_WRITER_CLIP_EN
                        state_next = ST_DRAIN;
`else
                        do_write   = 1'b1;
                        write_addr = frame_base_reg;
`endif
                    end else begin
                        do_write = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat_acc && st_endofpacket) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!mm_write_reg || !mm_waitrequest) begin
                    flush_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A start (fresh sop or abort-restart) always uses the base register as it was before this edge.
        if (do_start) begin
            state_next      = ST_WRITING;
            frame_base_next = base_reg;
            end_next        = base_reg + FRAME_A;
            err_next        = 1'b0;
            do_write        = 1'b1;
            write_addr      = base_reg;
        end

        if (do_write) begin
            mm_write_next     = 1'b1;
            mm_address_next   = write_addr;
            mm_writedata_next = st_data;
            wr_ptr_next       = write_addr + BPW_A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            base_reg         <= MM_START_ADDRESS;
            frame_base_reg   <= MM_START_ADDRESS;
            end_reg          <= '0;
            wr_ptr_reg       <= '0;
            err_reg          <= 1'b0;
            mm_write_reg     <= 1'b0;
            mm_address_reg   <= '0;
            mm_writedata_reg <= '0;
            pulse_done_reg   <= 1'b0;
            pulse_err_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            frame_base_reg   <= frame_base_next;
            end_reg          <= end_next;
            wr_ptr_reg       <= wr_ptr_next;
            err_reg          <= err_next;
            mm_write_reg     <= mm_write_next;
            mm_address_reg   <= mm_address_next;
            mm_writedata_reg <= mm_writedata_next;
            pulse_done_reg   <= pulse_done_next;
            pulse_err_reg    <= pulse_err_next;
            if (address_wr) begin
                base_reg <= address;
            end
        end
    end

endmodule
